// File: rtl/icnd2110_read_arbiter.sv
// ---------------------------------------------------------------------------
// icnd2110_read_arbiter
//
// Shares a single frame-buffer memory read port between CHANNELS output
// channels. Requests are granted round-robin, one per cycle at most. Every
// issued read carries a channel tag down a pipeline that lines up with the
// memory read latency. The returned word is presented on read_data together
// with a one-cycle, one-hot read_finished_strobe for the owning channel.
//
// A writer (e.g. the frame loader) takes the memory by raising mem_busy,
// which blocks new grants. It then waits for mem_idle before driving the
// memory itself.
//
// Ports
//   clk                   system clock, rising edge
//   rst                   asynchronous active-low reset
//   channel_enable        per-channel grant mask (0 = never granted)
//   req_request           per-channel read request
//   req_address           packed request addresses, channel i at [i*AW +: AW]
//   read_data             returned memory word, shared by all channels
//   read_finished_strobe  one-hot, one-cycle "read_data valid for channel i"
//   mem_address           memory read address
//   mem_read_enable       memory read strobe, one cycle per read
//   mem_read_data         memory data, valid READ_LATENCY cycles after enable
//   mem_busy              writer claims the memory; blocks new grants
//   mem_idle              no read issued or in flight (registered)
// ---------------------------------------------------------------------------
module icnd2110_read_arbiter #(
  parameter int CHANNELS          = 4,
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int READ_LATENCY      = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CHANNELS-1:0]                   channel_enable,
  input  logic [CHANNELS-1:0]                   req_request,
  input  logic [CHANNELS*ADDRESS_BUS_WIDTH-1:0] req_address,
  output logic [15:0]                           read_data,
  output logic [CHANNELS-1:0]                   read_finished_strobe,
  output logic [ADDRESS_BUS_WIDTH-1:0]          mem_address,
  output logic                                  mem_read_enable,
  input  logic [15:0]                           mem_read_data,
  input  logic                                  mem_busy,
  output logic                                  mem_idle
);

  localparam int IDW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TDEPTH = READ_LATENCY + 1;
  localparam int AW     = ADDRESS_BUS_WIDTH;

  // Decode a channel id into a one-hot channel vector.
  function automatic logic [CHANNELS-1:0] f_onehot(input logic [IDW-1:0] id);
    logic [CHANNELS-1:0] v;
    v = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      v[i] = (id == IDW'(i));
    end
    return v;
  endfunction

  // Registered state
  logic [IDW-1:0]          r_ptr;
  logic [CHANNELS-1:0]     r_pending;
  logic [CHANNELS-1:0]     r_holdoff;
  logic [TDEPTH-1:0]       r_tag_valid;
  logic [IDW-1:0]          r_tag_id [TDEPTH];
  logic [15:0]             r_read_data;
  logic [CHANNELS-1:0]     r_strobe;
  logic [AW-1:0]           r_mem_address;
  logic                    r_mem_read_enable;
  logic                    r_mem_idle;

  // Combinational arbitration results
  logic [CHANNELS-1:0]     w_eligible;
  logic [IDW-1:0]          w_scan_idx;
  logic                    w_grant_valid;
  logic [IDW-1:0]          w_grant_id;
  logic [CHANNELS-1:0]     w_grant_onehot;
  logic [AW-1:0]           w_grant_address;

  // A pending channel already has a read in flight (or is in holdoff), and a
  // busy writer blocks everybody.
  assign w_eligible = req_request & channel_enable & ~r_pending
                    & {CHANNELS{~mem_busy}};

  // Round-robin search starting one past the last winner, wrapping.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = '0;
    w_scan_idx    = '0;
    for (int off = 1; off <= CHANNELS; off++) begin
      w_scan_idx = IDW'((int'(r_ptr) + off) % CHANNELS);
      if (!w_grant_valid && w_eligible[w_scan_idx]) begin
        w_grant_valid = 1'b1;
        w_grant_id    = w_scan_idx;
      end else begin
        w_grant_valid = w_grant_valid;
        w_grant_id    = w_grant_id;
      end
    end
  end

  // Winner one-hot and the address of the winning channel.
  always_comb begin
    w_grant_onehot  = '0;
    w_grant_address = '0;
    if (w_grant_valid) begin
      w_grant_onehot = f_onehot(w_grant_id);
    end else begin
      w_grant_onehot = '0;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant_valid && (w_grant_id == IDW'(i))) begin
        w_grant_address = req_address[i*AW +: AW];
      end else begin
        w_grant_address = w_grant_address;
      end
    end
  end

  // Round-robin pointer: moves to the winner, unchanged without a grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= IDW'(CHANNELS - 1);
    end else if (w_grant_valid) begin
      r_ptr <= w_grant_id;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Memory issue: address is captured only in the grant cycle so later
  // request-address changes cannot disturb the in-flight read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_read_enable <= 1'b0;
      r_mem_address     <= '0;
    end else begin
      r_mem_read_enable <= w_grant_valid;
      if (w_grant_valid) begin
        r_mem_address <= w_grant_address;
      end else begin
        r_mem_address <= r_mem_address;
      end
    end
  end

  // Tag pipeline: stage 0 is aligned with mem_read_enable, stage
  // READ_LATENCY is aligned with valid mem_read_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_valid <= '0;
      for (int j = 0; j < TDEPTH; j++) begin
        r_tag_id[j] <= '0;
      end
    end else begin
      r_tag_valid[0] <= w_grant_valid;
      r_tag_id[0]    <= w_grant_id;
      for (int j = 1; j < TDEPTH; j++) begin
        r_tag_valid[j] <= r_tag_valid[j-1];
        r_tag_id[j]    <= r_tag_id[j-1];
      end
    end
  end

  // Return path: read_data holds between returns, strobe lasts one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_read_data <= 16'h0000;
      r_strobe    <= '0;
    end else if (r_tag_valid[READ_LATENCY]) begin
      r_read_data <= mem_read_data;
      r_strobe    <= f_onehot(r_tag_id[READ_LATENCY]);
    end else begin
      r_read_data <= r_read_data;
      r_strobe    <= '0;
    end
  end

  // Pending flags: set after the grant, cleared one cycle after the strobe
  // (r_holdoff) so the channel's FIFO full flag settles before its request
  // is looked at again. A pending channel is never granted, so the set and
  // clear terms can never hit the same bit together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
      r_holdoff <= '0;
    end else begin
      r_pending <= (r_pending & ~r_holdoff) | w_grant_onehot;
      r_holdoff <= r_strobe;
    end
  end

  // Idle flag for the writer handshake, one register behind the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_idle <= 1'b1;
    end else begin
      r_mem_idle <= ~r_mem_read_enable & ~(|r_tag_valid);
    end
  end

  assign read_data            = r_read_data;
  assign read_finished_strobe = r_strobe;
  assign mem_address          = r_mem_address;
  assign mem_read_enable      = r_mem_read_enable;
  assign mem_idle             = r_mem_idle;

endmodule

// File: tb/tb_icnd2110_read_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for icnd2110_read_arbiter. Two instances are used: u1 with
// READ_LATENCY=1 and u3 with READ_LATENCY=3. Each test pushes the expected
// memory issues and returns (with their exact cycle numbers) into queues; a
// monitor compares every mem_read_enable and read_finished_strobe it sees
// against the queue heads.
// ---------------------------------------------------------------------------
module tb_icnd2110_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  en;
  logic        busy;
  logic [3:0]  req1, req3;
  logic [63:0] addr1, addr3;
  logic [15:0] md1;
  logic [15:0] p0, p1, p2;

  logic [15:0] rd1, rd3;
  logic [3:0]  stb1, stb3;
  logic [15:0] ma1, ma3;
  logic        me1, me3;
  logic        idle1, idle3;

  logic        sel3;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          gcnt [4];

  typedef struct { int cyc; logic [15:0] addr; } iss_t;
  typedef struct { int cyc; logic [3:0] oh; logic [15:0] data; } ret_t;
  iss_t q_iss [$];
  ret_t q_ret [$];

  icnd2110_read_arbiter #(.CHANNELS(4), .ADDRESS_BUS_WIDTH(16), .READ_LATENCY(1)) u1 (
    .clk(clk), .rst(rst_n), .channel_enable(en), .req_request(req1),
    .req_address(addr1), .read_data(rd1), .read_finished_strobe(stb1),
    .mem_address(ma1), .mem_read_enable(me1), .mem_read_data(md1),
    .mem_busy(busy), .mem_idle(idle1));

  icnd2110_read_arbiter #(.CHANNELS(4), .ADDRESS_BUS_WIDTH(16), .READ_LATENCY(3)) u3 (
    .clk(clk), .rst(rst_n), .channel_enable(en), .req_request(req3),
    .req_address(addr3), .read_data(rd3), .read_finished_strobe(stb3),
    .mem_address(ma3), .mem_read_enable(me3), .mem_read_data(p2),
    .mem_busy(busy), .mem_idle(idle3));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA5A0 ^ a;
  endfunction

  // Memory models: latency 1 for u1, latency 3 for u3.
  always @(posedge clk) begin
    md1 <= mem_word(ma1);
    p0  <= mem_word(ma3);
    p1  <= p0;
    p2  <= p1;
  end

  wire        m_en   = sel3 ? me3  : me1;
  wire [15:0] m_addr = sel3 ? ma3  : ma1;
  wire [3:0]  m_stb  = sel3 ? stb3 : stb1;
  wire [15:0] m_data = sel3 ? rd3  : rd1;

  // Monitor: compare every observed issue and return with the queue heads.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_en) begin
        checks++;
        if (q_iss.size() == 0) begin
          errors++;
          $display("FAIL issue: unexpected read cycle %0d addr %h", cyc, m_addr);
        end else begin
          iss_t e;
          e = q_iss.pop_front();
          if (e.cyc != cyc || e.addr != m_addr) begin
            errors++;
            $display("FAIL issue: actual cycle %0d addr %h, required cycle %0d addr %h",
                     cyc, m_addr, e.cyc, e.addr);
          end
        end
      end
      if (|m_stb) begin
        checks++;
        for (int i = 0; i < 4; i++) if (m_stb[i]) gcnt[i]++;
        if (q_ret.size() == 0) begin
          errors++;
          $display("FAIL return: unexpected strobe %b cycle %0d data %h", m_stb, cyc, m_data);
        end else begin
          ret_t r;
          r = q_ret.pop_front();
          if (r.cyc != cyc || r.oh != m_stb || r.data != m_data) begin
            errors++;
            $display("FAIL return: actual cycle %0d strobe %b data %h, required cycle %0d strobe %b data %h",
                     cyc, m_stb, m_data, r.cyc, r.oh, r.data);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask

  // Expected read: issue cycle/address plus the return READ_LATENCY+1 later.
  task automatic exp_read(input int issue_cyc, input logic [15:0] a, input int ch, input int rl);
    iss_t e;
    ret_t r;
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    e.cyc = issue_cyc; e.addr = a;
    r.cyc = issue_cyc + rl + 1; r.oh = oh; r.data = mem_word(a);
    q_iss.push_back(e);
    q_ret.push_back(r);
  endtask

  task automatic set_addr1(input logic [15:0] base);
    for (int i = 0; i < 4; i++) addr1[i*16 +: 16] = base + 16'(i);
  endtask

  task automatic drained(input string nm);
    chk({nm, "_iss_left"}, 32'(q_iss.size()), 32'd0);
    chk({nm, "_ret_left"}, 32'(q_ret.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_mre"},  32'(me1),   32'd0);
    chk({nm, "_addr"}, 32'(ma1),   32'd0);
    chk({nm, "_rd"},   32'(rd1),   32'd0);
    chk({nm, "_stb"},  32'(stb1),  32'd0);
    chk({nm, "_idle"}, 32'(idle1), 32'd1);
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    req1 = 4'b0000; req3 = 4'b0000; busy = 1'b0; en = 4'b1111;
    #1;
    check_reset_vals(nm);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int b;
    rst_n = 1'b1; sel3 = 1'b0; en = 4'b1111; busy = 1'b0;
    req1 = 4'b0000; req3 = 4'b0000; addr1 = '0; addr3 = '0;
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    #2;

    // Latency: ch0 reads 0x0005 -> 0xA5A5; re-grant no earlier than 5 later.
    do_reset("rst0");
    tick(); b = cyc;
    addr1[15:0] = 16'h0005; req1 = 4'b0001;
    chk("first_word", 32'(mem_word(16'h0005)), 32'h0000A5A5);
    exp_read(b + 1, 16'h0005, 0, 1);
    exp_read(b + 6, 16'h0005, 0, 1);
    goto(b + 6); req1 = 4'b0000;
    goto(b + 14); drained("latency");
    chk("latency_rd_hold", 32'(rd1), 32'h0000A5A5);

    // Fairness: 4 channels continuously, grants 0,1,2,3 then one idle slot.
    do_reset("rst1");
    tick(); b = cyc;
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    set_addr1(16'h0010); req1 = 4'b1111;
    for (int m = 0; m < 8; m++)
      for (int i = 0; i < 4; i++)
        exp_read(b + 5*m + i + 1, 16'h0010 + 16'(i), i, 1);
    goto(b + 40); req1 = 4'b0000;
    goto(b + 50); drained("fair");
    for (int i = 0; i < 4; i++) chk($sformatf("fair_count%0d", i), 32'(gcnt[i]), 32'd8);

    // Writer handoff.
    do_reset("rst2");
    tick(); b = cyc;
    set_addr1(16'h0020); req1 = 4'b0011;
    exp_read(b + 1, 16'h0020, 0, 1);
    goto(b + 1); busy = 1'b1;
    for (int t = b + 2; t <= b + 9; t++) begin
      goto(t);
      chk($sformatf("idle_c%0d", t - b), 32'(idle1), (t >= b + 4) ? 32'd1 : 32'd0);
    end
    goto(b + 10); busy = 1'b0;
    exp_read(b + 11, 16'h0021, 1, 1);
    exp_read(b + 12, 16'h0020, 0, 1);
    goto(b + 12); req1 = 4'b0000;
    goto(b + 20); drained("handoff");

    // Masking: only ch1/ch3, then ch1 disabled while its read is in flight.
    do_reset("rst3");
    tick(); b = cyc;
    en = 4'b1010; set_addr1(16'h0030); req1 = 4'b1111;
    exp_read(b + 1,  16'h0031, 1, 1);
    exp_read(b + 2,  16'h0033, 3, 1);
    exp_read(b + 6,  16'h0031, 1, 1);
    exp_read(b + 7,  16'h0033, 3, 1);
    exp_read(b + 11, 16'h0031, 1, 1);
    exp_read(b + 12, 16'h0033, 3, 1);
    exp_read(b + 17, 16'h0033, 3, 1);
    exp_read(b + 22, 16'h0033, 3, 1);
    goto(b + 11); en = 4'b1000;
    goto(b + 22); req1 = 4'b0000;
    goto(b + 30); drained("mask");

    // Deep latency on u3: back-to-back issues, strobe 5 cycles after grant.
    do_reset("rst4");
    sel3 = 1'b1;
    tick(); b = cyc;
    for (int i = 0; i < 4; i++) addr3[i*16 +: 16] = 16'h0040 + 16'(i);
    req3 = 4'b1111;
    for (int i = 0; i < 4; i++) exp_read(b + 1 + i, 16'h0040 + 16'(i), i, 3);
    for (int i = 0; i < 4; i++) exp_read(b + 8 + i, 16'h0040 + 16'(i), i, 3);
    goto(b + 11); req3 = 4'b0000;
    goto(b + 20); drained("deep");
    sel3 = 1'b0;

    // Reset mid-flight: grant ch0, reset one cycle later, restart at ch0.
    do_reset("rst5");
    tick(); b = cyc;
    set_addr1(16'h0050); req1 = 4'b1111;
    goto(b + 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    goto(b + 2);
    rst_n = 1'b1;
    exp_read(b + 3, 16'h0050, 0, 1);
    exp_read(b + 4, 16'h0051, 1, 1);
    goto(b + 4); req1 = 4'b0000;
    goto(b + 12); drained("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icnd2110_read_arbiter.md
Name: icnd2110_read_arbiter

Overview:
Shares one frame-buffer memory read port between up to CHANNELS icnd2110_out output channels. It round-robins the channels' read_request/read_address pairs onto the single memory port, tracks each in-flight read by channel tag, and returns the data with a one-cycle read_finished_strobe to the owning channel. It also hands the memory off cleanly to a writer, such as the frame loader, through a busy/idle handshake.

Parameters:
CHANNELS, 4, number of requesting output channels (1..8)
ADDRESS_BUS_WIDTH, 16, width of every read address
READ_LATENCY, 1, cycles from mem_read_enable high to mem_read_data valid (1..4)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
channel_enable  input  CHANNELS  per-channel grant mask; 0 = never granted
req_request  input  CHANNELS  per-channel read request (the channel's read_request)
req_address  input  CHANNELS*ADDRESS_BUS_WIDTH  packed addresses; channel i at [i*AW +: AW]
read_data  output  16  returned word, shared by all channels
read_finished_strobe  output  CHANNELS  one-hot, one-cycle "read_data valid for channel i"
mem_address  output  ADDRESS_BUS_WIDTH  memory read address
mem_read_enable  output  1  memory read strobe, one cycle per read
mem_read_data  input  16  memory data, valid READ_LATENCY cycles after mem_read_enable
mem_busy  input  1  writer claims the memory; blocks new reads
mem_idle  output  1  high when no read is being issued or in flight

Behaviour:
- Reset (rst low, async) values:
  - mem_read_enable=0, mem_address=0, read_data=0, read_finished_strobe=0, mem_idle=1.
  - All pending/holdoff flags cleared and tag pipeline emptied.
  - RR pointer = CHANNELS-1, so channel 0 wins first.
- Eligibility in cycle k: channel i is eligible when req_request[i] & channel_enable[i] & ~pending[i] & ~mem_busy.
- Arbitration:
  - Round-robin over the eligible channels, searching from pointer+1 with wrap modulo CHANNELS.
  - The winner w updates the pointer to w.
  - At most one grant per cycle.
  - No eligible channel means no grant and the pointer is unchanged.
- Issue: a grant in cycle k registers mem_address=req_address[w] and mem_read_enable=1, both visible in cycle k+1. mem_read_enable is 0 in any cycle that does not follow a grant.
- Tag pipeline: {valid, channel id} shift register of depth READ_LATENCY+1. It captures mem_read_data in cycle k+1+READ_LATENCY.
- Return:
  - read_data and read_finished_strobe[w] are registered and high in cycle k+2+READ_LATENCY for exactly one cycle.
  - read_data holds its value until the next return.
  - Total latency from grant to strobe is READ_LATENCY+2 cycles.
- Pending/holdoff:
  - pending[w] sets in cycle k+1 and stays set through the strobe cycle plus one further cycle.
  - This holdoff lets the channel's FIFO full flag update before its request is re-sampled.
  - Consequence: at most one read per channel is in flight.
  - Channel rate is at most one read per READ_LATENCY+4 cycles. Aggregate rate is one read per cycle when at least READ_LATENCY+4 channels are active.
- Address sampling: req_address is sampled only in the grant cycle. Later changes do not affect the in-flight read.
- mem_busy:
  - High in cycle k means no grant in cycle k.
  - Reads already issued complete and strobe normally.
  - mem_idle = ~mem_read_enable & (tag pipeline empty), registered. The writer must wait for mem_busy high AND mem_idle high before driving the memory.
- channel_enable:
  - Clearing a bit blocks future grants only.
  - An in-flight read for that channel still strobes.
- Simultaneous events:
  - A request that drops in the same cycle it would have been granted is not granted; eligibility uses current-cycle values.
  - A strobe for one channel and a grant for another in the same cycle are independent.
- Reset mid-operation: in-flight reads are discarded and no strobe is emitted for them. After rst rises, arbitration restarts at channel 0.

Test Plan:
- Latency: READ_LATENCY=1; ch0 requests addr 0x0005 in cycle 0; memory returns 0xA5A5 → mem_read_enable with mem_address=0x0005 in cycle 1 only; strobe[0] with read_data=0xA5A5 in cycle 3; next ch0 mem_read_enable no earlier than cycle 6.
- Fairness: all 4 channels request continuously at distinct addresses 0x10..0x13 → grants 0,1,2,3,0,…; each strobe carries its own channel's memory word; over 40 cycles the grant counts differ by at most 1.
- Writer handoff: mem_busy rises in the cycle after one grant → that read still strobes; no further mem_read_enable while mem_busy=1; mem_idle=1 exactly READ_LATENCY+2 cycles after the last mem_read_enable; grants resume the cycle mem_busy falls.
- Masking: channel_enable=4'b1010 with all 4 channels requesting → only channels 1 and 3 are granted, alternating; clearing bit 1 while ch1 is in flight → ch1 still strobes once, then only ch3 is granted.
- Deep latency: READ_LATENCY=3, 4 channels requesting → back-to-back mem_read_enable; each strobe arrives 5 cycles after its grant with the correct one-hot tag and data.
- Reset mid-flight: rst low one cycle after a grant → all outputs at reset values immediately (async); no stray strobe afterwards; first post-reset grant goes to ch0.
